// File: rtl/accum_cpu_if.sv
`default_nettype none
// ============================================================================
// Module      : accum_cpu_if
// Description : Memory bus between the accumulator core (master) and a
//               single-port word memory (slave). A transfer completes in any
//               cycle where mem_ready=1 while mem_rd or mem_wr is raised.
// Revision    : 1.0 - initial release
// ============================================================================
interface accum_cpu_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/accum_cpu.sv
`default_nettype none
// ============================================================================
// Module      : accum_cpu
// Description : Multi-cycle accumulator CPU. Fetches one-word opcodes and an
//               optional address operand, executes against accumulator A,
//               helper register B and flags Z/C. Bus requests are Moore
//               outputs that hold steady until the memory accepts them.
//               The interface instance must use the same DATA_W/ADDR_W.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  accum_cpu_if.master       bus,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDA  = 8'h01;
  localparam logic [7:0] OP_STA  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_AND  = 8'h05;
  localparam logic [7:0] OP_TAB  = 8'h06;
  localparam logic [7:0] OP_JMP  = 8'h07;
  localparam logic [7:0] OP_JZ   = 8'h08;
  localparam logic [7:0] OP_JC   = 8'h09;
  localparam logic [7:0] OP_ADDB = 8'h10;
  localparam logic [7:0] OP_HLT  = 8'hFF;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_OPERAND = 3'd1,
    ST_DATA_RD = 3'd2,
    ST_DATA_WR = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] opa, opa_nxt;
  logic [DATA_W-1:0] a, a_nxt;
  logic [DATA_W-1:0] b, b_nxt;
  logic              z, z_nxt;
  logic              c, c_nxt;
  logic              ill, ill_nxt;
  // Only the opcode byte is kept; upper instruction bits carry no meaning.
  logic [7:0]        ir, ir_nxt;

  logic [7:0]        fetch_op;
  logic [ADDR_W-1:0] operand_addr;
  logic [ADDR_W-1:0] pc_inc;
  logic [DATA_W:0]   sum_m;
  logic [DATA_W:0]   sum_b;
  logic [DATA_W-1:0] diff_m;

  assign fetch_op     = bus.mem_rdata[7:0];
  assign operand_addr = bus.mem_rdata[ADDR_W-1:0];
  assign pc_inc       = pc + PC_ONE;
  assign sum_m        = {1'b0, a} + {1'b0, bus.mem_rdata};
  assign sum_b        = {1'b0, a} + {1'b0, b};
  assign diff_m       = a - bus.mem_rdata;

  // Architectural state register; reset wins over any pending access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= '0;
      opa   <= '0;
      a     <= '0;
      b     <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
      ill   <= 1'b0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      opa   <= opa_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
      z     <= z_nxt;
      c     <= c_nxt;
      ill   <= ill_nxt;
      ir    <= ir_nxt;
    end
  end

  // Next-state and execute logic; nothing moves unless the access is accepted.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    opa_nxt   = opa;
    a_nxt     = a;
    b_nxt     = b;
    z_nxt     = z;
    c_nxt     = c;
    ill_nxt   = ill;
    ir_nxt    = ir;
    case (state)
      ST_FETCH: begin
        if (bus.mem_ready) begin
          ir_nxt = fetch_op;
          pc_nxt = pc_inc;
          case (fetch_op)
            OP_NOP: begin
            end
            OP_TAB: b_nxt = a;
            OP_ADDB: begin
              a_nxt = sum_b[DATA_W-1:0];
              c_nxt = sum_b[DATA_W];
              z_nxt = (sum_b[DATA_W-1:0] == '0);
            end
            OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND,
            OP_JMP, OP_JZ, OP_JC: state_nxt = ST_OPERAND;
            OP_HLT: state_nxt = ST_HALT;
            default: begin
              state_nxt = ST_HALT;
              ill_nxt   = 1'b1;
            end
          endcase
        end
      end
      ST_OPERAND: begin
        if (bus.mem_ready) begin
          opa_nxt   = operand_addr;
          pc_nxt    = pc_inc;
          state_nxt = ST_FETCH;
          case (ir)
            OP_JMP: pc_nxt = operand_addr;
            OP_JZ:  if (z) pc_nxt = operand_addr;
            OP_JC:  if (c) pc_nxt = operand_addr;
            OP_STA: state_nxt = ST_DATA_WR;
            OP_LDA, OP_ADD, OP_SUB, OP_AND: state_nxt = ST_DATA_RD;
            default: state_nxt = ST_FETCH;
          endcase
        end
      end
      ST_DATA_RD: begin
        if (bus.mem_ready) begin
          state_nxt = ST_FETCH;
          case (ir)
            OP_LDA: begin
              a_nxt = bus.mem_rdata;
              z_nxt = (bus.mem_rdata == '0);
            end
            OP_ADD: begin
              a_nxt = sum_m[DATA_W-1:0];
              c_nxt = sum_m[DATA_W];
              z_nxt = (sum_m[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              a_nxt = diff_m;
              c_nxt = (a < bus.mem_rdata);
              z_nxt = (diff_m == '0);
            end
            OP_AND: begin
              a_nxt = a & bus.mem_rdata;
              c_nxt = 1'b0;
              z_nxt = ((a & bus.mem_rdata) == '0);
            end
            default: begin
            end
          endcase
        end
      end
      ST_DATA_WR: begin
        if (bus.mem_ready) state_nxt = ST_FETCH;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Bus requests follow the state; they are squashed during the reset cycle.
  assign bus.mem_rd    = !rst && ((state == ST_FETCH) || (state == ST_OPERAND) ||
                                  (state == ST_DATA_RD));
  assign bus.mem_wr    = !rst && (state == ST_DATA_WR);
  assign bus.mem_addr  = ((state == ST_DATA_RD) || (state == ST_DATA_WR)) ? opa : pc;
  assign bus.mem_wdata = a;

  assign halted  = (state == ST_HALT);
  assign illegal = ill;
  assign pc_out  = pc;
  assign acc_out = a;

endmodule
`default_nettype wire

// File: tb/tb_accum_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_cpu
// Description : Self-checking bench for accum_cpu: directed programs, reset
//               behaviour, random programs against an instruction-level model
//               with and without memory stalls, and a 16/10-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_cpu;
  logic clk = 1'b0;
  logic rst, rst_w;
  always #5 clk = ~clk;

  int checks, failures;

  // ---------------- 8/8 instance with stallable memory ----------------
  accum_cpu_if #(.DATA_W(8), .ADDR_W(8)) bus ();
  logic       halted, illegal;
  logic [7:0] pc_out, acc_out;

  accum_cpu #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .halted(halted), .illegal(illegal), .pc_out(pc_out), .acc_out(acc_out)
  );

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [7:0] mm  [256];
  logic       load_req;
  logic       ready_drv;
  int         ready_mode;   // 0 zero-wait, 1 random stalls, 2 manual
  int         wait_left;

  assign bus.mem_ready = ready_drv;
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (bus.mem_wr && bus.mem_ready) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (ready_mode == 0) ready_drv = 1'b1;
    else if (ready_mode == 1) begin
      if (bus.mem_rd || bus.mem_wr) begin
        if (wait_left == 0) begin
          ready_drv = 1'b1;
          wait_left = $urandom_range(0, 5);
        end else begin
          ready_drv = 1'b0;
          wait_left--;
        end
      end else ready_drv = 1'($urandom_range(0, 1));
    end
  end

  // Request stability while stalled
  logic       mon_en, snap_v, snap_rd, snap_wr;
  logic [7:0] snap_addr, snap_wdata;
  always @(posedge clk) begin
    snap_v     = mon_en && !rst && (bus.mem_rd || bus.mem_wr) && !bus.mem_ready;
    snap_rd    = bus.mem_rd;
    snap_wr    = bus.mem_wr;
    snap_addr  = bus.mem_addr;
    snap_wdata = bus.mem_wdata;
  end
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bus.mem_rd && bus.mem_wr) begin
        failures++;
        $display("FAIL rd_wr_exclusive: got rd=1 wr=1 required not both");
      end
      if (snap_v) begin
        checks++;
        if ({bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !==
            {snap_rd, snap_wr, snap_addr, snap_wdata}) begin
          failures++;
          $display("FAIL stall_hold: got rd=%0b wr=%0b addr=%0h wd=%0h required rd=%0b wr=%0b addr=%0h wd=%0h",
                   bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
                   snap_rd, snap_wr, snap_addr, snap_wdata);
        end
      end
    end
  end

  // ---------------- 16/10 instance with zero-wait memory ----------------
  accum_cpu_if #(.DATA_W(16), .ADDR_W(10)) bus_w ();
  logic        halted_w, illegal_w;
  logic [9:0]  pc_w;
  logic [15:0] acc_w;

  accum_cpu #(.DATA_W(16), .ADDR_W(10)) dut_w (
    .clk(clk), .rst(rst_w), .bus(bus_w),
    .halted(halted_w), .illegal(illegal_w), .pc_out(pc_w), .acc_out(acc_w)
  );

  logic [15:0] mem_w [1024];
  logic [15:0] img_w [1024];
  logic        load_w;
  assign bus_w.mem_ready = 1'b1;
  assign bus_w.mem_rdata = mem_w[bus_w.mem_addr];
  always @(posedge clk) begin
    if (load_w) begin
      for (int i = 0; i < 1024; i++) mem_w[i] <= img_w[i];
    end else if (bus_w.mem_wr) begin
      mem_w[bus_w.mem_addr] <= bus_w.mem_wdata;
    end
  end

  // ---------------- instruction-level reference model ----------------
  int m_a, m_b, m_z, m_c, m_pc, m_ill, m_cyc;

  task automatic model_run();
    int pcv, op, ad, m, s;
    bit done;
    m_a = 0; m_b = 0; m_z = 0; m_c = 0; m_ill = 0; m_cyc = 0; pcv = 0; done = 0;
    for (int step = 0; step < 500 && !done; step++) begin
      op = int'(mm[pcv]);
      pcv = (pcv + 1) % 256;
      if (op == 0) m_cyc += 1;
      else if (op == 6) begin m_b = m_a; m_cyc += 1; end
      else if (op == 16) begin
        s = m_a + m_b; m_c = (s > 255) ? 1 : 0; m_a = s % 256;
        m_z = (m_a == 0) ? 1 : 0; m_cyc += 1;
      end
      else if (op == 255) begin m_cyc += 1; done = 1; end
      else if (op >= 1 && op <= 9) begin
        ad = int'(mm[pcv]);
        pcv = (pcv + 1) % 256;
        if (op >= 7) begin
          m_cyc += 2;
          if (op == 7 || (op == 8 && m_z == 1) || (op == 9 && m_c == 1)) pcv = ad;
        end else begin
          m_cyc += 3;
          m = int'(mm[ad]);
          case (op)
            1: m_a = m;
            2: mm[ad] = 8'(m_a);
            3: begin s = m_a + m; m_c = (s > 255) ? 1 : 0; m_a = s % 256; end
            4: begin m_c = (m_a < m) ? 1 : 0; m_a = (m_a - m + 256) % 256; end
            default: begin m_a = m_a & m; m_c = 0; end
          endcase
          if (op != 2) m_z = (m_a == 0) ? 1 : 0;
        end
      end else begin m_cyc += 1; m_ill = 1; done = 1; end
    end
    m_pc = pcv;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'hFF;
  endtask

  // Reset, load image, release and count edges until halted.
  task automatic run_dut(input int mode, output int cyc, output bit to);
    ready_mode = mode;
    @(negedge clk); rst = 1'b1; load_req = 1'b1;
    @(negedge clk); load_req = 1'b0; rst = 1'b0;
    cyc = 0; to = 1'b0;
    while (!halted) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin to = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_program();
    int cyc; bit to;
    clear_img();
    img[0] = 8'h01; img[1] = 8'hFE; img[2] = 8'h06; img[3] = 8'h01; img[4] = 8'hFF;
    img[5] = 8'h10; img[6] = 8'h02; img[7] = 8'hFF; img[8] = 8'hFF;
    img[8'hFE] = 8'h01; img[8'hFF] = 8'h01;
    run_dut(0, cyc, to);
    checks++; if (to || halted !== 1'b1) begin failures++; $display("FAIL prog_halt: got %0b required 1", halted); end
    checks++; if (cyc !== 12) begin failures++; $display("FAIL prog_cycles: got %0d required 12", cyc); end
    checks++; if (acc_out !== 8'h02) begin failures++; $display("FAIL prog_acc: got %0h required 02", acc_out); end
    checks++; if (mem[8'hFF] !== 8'h02) begin failures++; $display("FAIL prog_mem: got %0h required 02", mem[8'hFF]); end
    checks++; if (illegal !== 1'b0 || pc_out !== 8'h09) begin failures++; $display("FAIL prog_ill_pc: got ill=%0b pc=%0h required ill=0 pc=09", illegal, pc_out); end
  endtask

  task automatic test_carry();
    int cyc; bit to;
    clear_img();
    img[0] = 8'h01; img[1] = 8'h80; img[2] = 8'h03; img[3] = 8'h81; img[4] = 8'h09; img[5] = 8'h20;
    img[8'h20] = 8'h08; img[8'h21] = 8'h30;
    img[8'h80] = 8'hFF; img[8'h81] = 8'h01;
    run_dut(0, cyc, to);
    checks++; if (to || halted !== 1'b1) begin failures++; $display("FAIL carry_halt: got %0b required 1", halted); end
    checks++; if (acc_out !== 8'h00) begin failures++; $display("FAIL carry_acc: got %0h required 00", acc_out); end
    checks++; if (pc_out !== 8'h31) begin failures++; $display("FAIL carry_jc_jz_pc: got %0h required 31", pc_out); end
    checks++; if (cyc !== 11) begin failures++; $display("FAIL carry_cycles: got %0d required 11", cyc); end
  endtask

  task automatic test_sub();
    int cyc; bit to;
    clear_img();
    img[0] = 8'h01; img[1] = 8'h80; img[2] = 8'h04; img[3] = 8'h81;
    img[4] = 8'h08; img[5] = 8'h40; img[6] = 8'h09; img[7] = 8'h20;
    img[8'h80] = 8'h03; img[8'h81] = 8'h05;
    run_dut(0, cyc, to);
    checks++; if (to || halted !== 1'b1) begin failures++; $display("FAIL sub_halt: got %0b required 1", halted); end
    checks++; if (acc_out !== 8'hFE) begin failures++; $display("FAIL sub_acc: got %0h required fe", acc_out); end
    checks++; if (pc_out !== 8'h21) begin failures++; $display("FAIL sub_flags_pc: got %0h required 21", pc_out); end
  endtask

  task automatic test_illegal();
    int cyc, reqs; bit to;
    clear_img();
    img[0] = 8'h07; img[1] = 8'h10; img[8'h10] = 8'h42;
    run_dut(0, cyc, to);
    checks++; if (to || halted !== 1'b1 || illegal !== 1'b1) begin failures++; $display("FAIL ill_flags: got h=%0b i=%0b required h=1 i=1", halted, illegal); end
    checks++; if (pc_out !== 8'h11) begin failures++; $display("FAIL ill_pc: got %0h required 11", pc_out); end
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_rd || bus.mem_wr) reqs++;
    end
    checks++; if (reqs !== 0) begin failures++; $display("FAIL ill_no_requests: got %0d required 0", reqs); end
  endtask

  task automatic test_reset();
    int cyc; bit to;
    ready_mode = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if ({pc_out, acc_out} !== 16'h0000) begin failures++; $display("FAIL rst_pc_acc: got pc=%0h acc=%0h required 0 0", pc_out, acc_out); end
    checks++; if ({halted, illegal, bus.mem_rd, bus.mem_wr} !== 4'b0000) begin failures++; $display("FAIL rst_ctrl: got h=%0b i=%0b rd=%0b wr=%0b required all 0", halted, illegal, bus.mem_rd, bus.mem_wr); end
    rst = 1'b0; #1;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h00) begin failures++; $display("FAIL rst_first_fetch: got rd=%0b addr=%0h required rd=1 addr=00", bus.mem_rd, bus.mem_addr); end
    // flags cleared: JZ and JC must both fall through
    clear_img();
    img[0] = 8'h08; img[1] = 8'h06; img[2] = 8'h09; img[3] = 8'h06;
    run_dut(0, cyc, to);
    checks++; if (to || pc_out !== 8'h05) begin failures++; $display("FAIL rst_flags_pc: got %0h required 05", pc_out); end
  endtask

  task automatic test_rst_mid_sta();
    int n; bit to;
    clear_img();
    img[0] = 8'h01; img[1] = 8'h80; img[2] = 8'h02; img[3] = 8'h90;
    img[8'h80] = 8'h5A; img[8'h90] = 8'h00;
    ready_mode = 2; ready_drv = 1'b1;
    @(negedge clk); rst = 1'b1; load_req = 1'b1;
    @(negedge clk); load_req = 1'b0; rst = 1'b0;
    n = 0;
    while (!bus.mem_wr && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.mem_wr !== 1'b1) begin failures++; $display("FAIL sta_reach_wr: got %0b required 1", bus.mem_wr); end
    ready_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h90, 8'h5A}) begin
        failures++;
        $display("FAIL sta_wait_hold: got wr=%0b addr=%0h wd=%0h required 1 90 5a", bus.mem_wr, bus.mem_addr, bus.mem_wdata);
      end
    end
    rst = 1'b1; ready_drv = 1'b1;
    @(negedge clk);
    checks++; if ({bus.mem_rd, bus.mem_wr} !== 2'b00 || mem[8'h90] !== 8'h00) begin failures++; $display("FAIL sta_abandon: got rd=%0b wr=%0b mem=%0h required 0 0 00", bus.mem_rd, bus.mem_wr, mem[8'h90]); end
    ready_drv = 1'b0; rst = 1'b0; #1;
    checks++; if ({bus.mem_rd, bus.mem_wr, bus.mem_addr} !== {2'b10, 8'h00}) begin failures++; $display("FAIL sta_refetch: got rd=%0b wr=%0b addr=%0h required 1 0 00", bus.mem_rd, bus.mem_wr, bus.mem_addr); end
    ready_drv = 1'b1;
    n = 0; to = 1'b0;
    while (!halted) begin @(negedge clk); n++; if (n > 100) begin to = 1'b1; break; end end
    checks++; if (to || acc_out !== 8'h5A || mem[8'h90] !== 8'h5A || pc_out !== 8'h05) begin failures++; $display("FAIL sta_rerun: got acc=%0h mem=%0h pc=%0h required 5a 5a 05", acc_out, mem[8'h90], pc_out); end
    ready_mode = 0;
  endtask

  task automatic test_random(input int mode, input int nprog);
    int tbl[11]; int term[4]; int ops[16]; int at[17];
    int n, p, cyc, bad; bit to;
    tbl = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16};
    term = '{255, 255, 10, 66};
    mon_en = (mode == 1);
    for (int k = 0; k < nprog; k++) begin
      for (int i = 0; i < 256; i++) img[i] = (i < 128) ? 8'hFF : 8'($urandom_range(0, 255));
      n = $urandom_range(4, 14); p = 0;
      for (int i = 0; i < n; i++) begin
        ops[i] = tbl[$urandom_range(0, 10)];
        at[i] = p;
        p += (ops[i] >= 1 && ops[i] <= 9 && ops[i] != 6) ? 2 : 1;
      end
      at[n] = p;
      for (int i = 0; i < n; i++) begin
        img[at[i]] = 8'(ops[i]);
        if (ops[i] >= 1 && ops[i] <= 9 && ops[i] != 6)
          img[at[i] + 1] = (ops[i] >= 7) ? 8'(at[$urandom_range(i + 1, n)])
                                         : 8'($urandom_range(128, 255));
      end
      img[at[n]] = 8'(term[$urandom_range(0, 3)]);
      for (int i = 0; i < 256; i++) mm[i] = img[i];
      model_run();
      run_dut(mode, cyc, to);
      checks++; if (to || halted !== 1'b1) begin failures++; $display("FAIL rnd%0d_halt: got %0b required 1", mode, halted); end
      checks++; if (acc_out !== 8'(m_a)) begin failures++; $display("FAIL rnd%0d_acc: got %0h required %0h", mode, acc_out, m_a); end
      checks++; if (pc_out !== 8'(m_pc)) begin failures++; $display("FAIL rnd%0d_pc: got %0h required %0h", mode, pc_out, m_pc); end
      checks++; if (illegal !== 1'(m_ill)) begin failures++; $display("FAIL rnd%0d_illegal: got %0b required %0d", mode, illegal, m_ill); end
      bad = 0;
      for (int i = 128; i < 256; i++) if (mem[i] !== mm[i]) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL rnd%0d_mem: got %0d differing words required 0", mode, bad); end
      if (mode == 0) begin
        checks++; if (cyc !== m_cyc) begin failures++; $display("FAIL rnd_cycles: got %0d required %0d", cyc, m_cyc); end
      end
    end
    mon_en = 1'b0;
    ready_mode = 0;
  endtask

  task automatic test_wide();
    int n; bit to, saw_wrap; logic [9:0] prev;
    for (int i = 0; i < 1024; i++) img_w[i] = 16'hFFFF;
    img_w[0] = 16'h0009; img_w[1] = 16'h0200;
    img_w[2] = 16'h0001; img_w[3] = 16'h0100;
    img_w[4] = 16'h0003; img_w[5] = 16'h0101;
    img_w[6] = 16'hAB07; img_w[7] = 16'h03FF;
    img_w[10'h3FF] = 16'h0000;
    img_w[10'h200] = 16'h0008; img_w[10'h201] = 16'h0300;
    img_w[10'h100] = 16'hFFFF; img_w[10'h101] = 16'h0001;
    @(negedge clk); rst_w = 1'b1; load_w = 1'b1;
    @(negedge clk); load_w = 1'b0; rst_w = 1'b0;
    n = 0; to = 1'b0; saw_wrap = 1'b0; prev = pc_w;
    while (!halted_w) begin
      @(negedge clk); n++;
      if (prev == 10'h3FF && pc_w == 10'h000) saw_wrap = 1'b1;
      prev = pc_w;
      if (n > 200) begin to = 1'b1; break; end
    end
    checks++; if (to || halted_w !== 1'b1 || illegal_w !== 1'b0) begin failures++; $display("FAIL wide_halt: got h=%0b i=%0b required 1 0", halted_w, illegal_w); end
    checks++; if (saw_wrap !== 1'b1) begin failures++; $display("FAIL wide_pc_wrap: got %0b required 1", saw_wrap); end
    checks++; if (acc_w !== 16'h0000 || pc_w !== 10'h301) begin failures++; $display("FAIL wide_carry_zero: got acc=%0h pc=%0h required 0000 301", acc_w, pc_w); end
    checks++; if (n !== 16) begin failures++; $display("FAIL wide_cycles: got %0d required 16", n); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rst_w = 1'b1; load_req = 1'b0; load_w = 1'b0;
    ready_mode = 0; ready_drv = 1'b1; wait_left = 0; mon_en = 1'b0;
    repeat (2) @(negedge clk);
    test_program();
    test_carry();
    test_sub();
    test_illegal();
    test_reset();
    test_rst_mid_sta();
    test_random(0, 10);
    test_random(1, 10);
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
